// File: rtl/vga_pkg.sv
// Shared 800x600@60 raster geometry, consumed by vga_timing, the game renderer
// and the capture configuration so the 1056x628 frame is defined only here.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 40;
    localparam int H_SYNC   = 128;
    localparam int H_BP     = 88;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 23;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are inclusive on both ends: 840..967 and 601..604.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam int   CE_NUM   = 2;
    localparam int   CE_DEN   = 5;
    localparam logic SYNC_POL = 1'b1;

    localparam int HW = 11;
    localparam int VW = 10;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic line_start;
        logic frame_start;
    } raster_flags_t;

    function automatic logic in_span(input int val, input int lo, input int hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle from vga_timing to its consumers (game renderer, capture path).
interface vga_timing_if;
    import vga_pkg::*;

    logic          pix_ce;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          hs;
    logic          vs;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic          pclk_mirror;

    modport master (
        output pix_ce, hcount, vcount, hs, vs, active,
               line_start, frame_start, pclk_mirror
    );

    modport slave (
        input  pix_ce, hcount, vcount, hs, vs, active,
               line_start, frame_start, pclk_mirror
    );

endinterface

// File: rtl/frac_ce_gen.sv
// Fractional clock-enable: a registered strobe that fires CE_NUM out of every
// CE_DEN clk cycles, spread as evenly as a modulo accumulator allows.
module frac_ce_gen #(
    parameter int CE_NUM = 2,
    parameter int CE_DEN = 5
) (
    input  logic clk,
    input  logic rst,
    output logic ce
);

    localparam int AW = $clog2(CE_DEN);
    localparam logic [AW:0] NUM_W = (AW+1)'(CE_NUM);
    localparam logic [AW:0] DEN_W = (AW+1)'(CE_DEN);

    logic [AW-1:0] acc;
    logic [AW:0]   sum;
    logic [AW:0]   acc_next;
    logic          wrap;

    // NOTE: every signal written in always_comb gets a value on every path,
    // here by straight-line assignment, so no latch can be inferred.
    always_comb begin
        sum      = {1'b0, acc} + NUM_W;
        wrap     = (sum >= DEN_W);
        acc_next = wrap ? (sum - DEN_W) : sum;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            acc <= acc_next[AW-1:0];
            ce  <= wrap;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// SVGA raster generator: pixel strobe, h/v counters and registered sync/blank
// decodes, all in the single clk domain with a fractional pixel enable.
module vga_timing
    import vga_pkg::HW, vga_pkg::VW, vga_pkg::raster_flags_t, vga_pkg::in_span;
#(
    parameter int   H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter int   CE_NUM   = vga_pkg::CE_NUM,
    parameter int   CE_DEN   = vga_pkg::CE_DEN,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam raster_flags_t FLAGS_RST = '{
        hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0,
        line_start: 1'b0, frame_start: 1'b0
    };

    logic          pix_ce;
    logic          ce_d1;
    logic          pclk_q;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    raster_flags_t flags;
    raster_flags_t flags_next;

    frac_ce_gen #(
        .CE_NUM (CE_NUM),
        .CE_DEN (CE_DEN)
    ) u_ce_gen (
        .clk (clk),
        .rst (rst),
        .ce  (pix_ce)
    );

    // Decode from the post-strobe coordinates so the flags register on the
    // same edge as the counters and stay cycle-aligned with them.
    always_comb begin
        h_next = hcount + 1'b1;
        v_next = vcount;
        if (hcount == H_LAST) begin
            h_next = '0;
            v_next = (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end

        flags_next.hs = in_span(int'(h_next), H_SYNC_START, H_SYNC_END)
                        ? SYNC_POL : ~SYNC_POL;
        flags_next.vs = in_span(int'(v_next), V_SYNC_START, V_SYNC_END)
                        ? SYNC_POL : ~SYNC_POL;
        flags_next.active      = (int'(h_next) < H_ACTIVE) && (int'(v_next) < V_ACTIVE);
        flags_next.line_start  = (h_next == '0);
        flags_next.frame_start = (h_next == '0) && (v_next == '0);
    end

    // Reset parks the counters on the last pixel so the first strobe lands on (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= H_LAST;
            vcount <= V_LAST;
            flags  <= FLAGS_RST;
            ce_d1  <= 1'b0;
            pclk_q <= 1'b0;
        end else begin
            ce_d1  <= pix_ce;
            pclk_q <= ce_d1;
            if (pix_ce) begin
                hcount <= h_next;
                vcount <= v_next;
                flags  <= flags_next;
            end else begin
                flags.line_start  <= 1'b0;
                flags.frame_start <= 1'b0;
            end
        end
    end

    assign vga.pix_ce      = pix_ce;
    assign vga.hcount      = hcount;
    assign vga.vcount      = vcount;
    assign vga.hs          = flags.hs;
    assign vga.vs          = flags.vs;
    assign vga.active      = flags.active;
    assign vga.line_start  = flags.line_start;
    assign vga.frame_start = flags.frame_start;
    assign vga.pclk_mirror = pclk_q;

endmodule
